// File: rtl/merge_layer_2_1_rx.sv
`default_nettype none
// ============================================================================
// Module   : merge_layer_2_1_rx
// Purpose  : Receives two ascending sorted streams (A and B) using the
//            update/data/done protocol. Each stream is buffered in its own
//            local FIFO, and the two are merged into one ascending stream
//            on the same protocol, so this block can feed the next merge level.
// Ports    : clk, rst (sync, active-high), load (start a merge from IDLE),
//            a_update/a_data/a_done, b_update/b_data/b_done (input streams),
//            update/sorted_data/done (merged stream), busy, overflow (sticky
//            dropped-push flag), out_count (elements emitted since load).
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// merge_layer_2_1_rx_fifo : small FIFO with a registered head and no fall-through.
// i_clr empties the FIFO; a push on the same cycle is then written into the
// freshly emptied FIFO. o_drop flags a push that was lost because the FIFO
// was full and no pop happened on the same cycle.
// ----------------------------------------------------------------------------
module merge_layer_2_1_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic                  o_drop
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wp;
  logic [AW:0]           r_rp;
  logic                  w_full;
  logic                  w_wr;
  logic [AW-1:0]         w_wr_idx;

  // The extra pointer bit separates full from empty when the index bits match
  assign o_empty  = (r_wp == r_rp);
  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head   = r_mem[r_rp[AW-1:0]];
  // A full FIFO still accepts a push when it pops on the same cycle
  assign w_wr     = i_push && (i_clr || !w_full || i_pop);
  assign o_drop   = i_push && !i_clr && w_full && !i_pop;
  assign w_wr_idx = i_clr ? '0 : r_wp[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_clr) begin
      r_rp <= '0;
      r_wp <= w_wr ? (AW+1)'(1) : '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + (AW+1)'(1);
      if (i_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[w_wr_idx] <= i_din;
  end
endmodule

// ----------------------------------------------------------------------------
// merge_layer_2_1_rx : top level
// ----------------------------------------------------------------------------
module merge_layer_2_1_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  a_update,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_done,
  input  logic                  b_update,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_done,
  output logic                  update,
  output logic [DATA_WIDTH-1:0] sorted_data,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow,
  output logic [CNT_W-1:0]      out_count
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MERGE   = 3'd1,
    S_DRAIN_A = 3'd2,
    S_DRAIN_B = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_a_fin;
  logic                  r_b_fin;
  logic                  w_load_acc;
  logic                  w_accept_in;
  logic                  w_push_a;
  logic                  w_push_b;
  logic                  w_pop_a;
  logic                  w_pop_b;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_emit_data;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;
  logic                  w_empty_a;
  logic                  w_empty_b;
  logic                  w_drop_a;
  logic                  w_drop_b;

  // Inputs are only listened to while a merge is running, plus the load cycle
  assign w_load_acc  = load && (r_state == S_IDLE);
  assign w_accept_in = w_load_acc || (r_state == S_MERGE) ||
                       (r_state == S_DRAIN_A) || (r_state == S_DRAIN_B);
  assign w_push_a    = a_update && w_accept_in;
  assign w_push_b    = b_update && w_accept_in;

  merge_layer_2_1_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_load_acc),
    .i_push  (w_push_a),
    .i_din   (a_data),
    .i_pop   (w_pop_a),
    .o_head  (w_head_a),
    .o_empty (w_empty_a),
    .o_drop  (w_drop_a)
  );

  merge_layer_2_1_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_load_acc),
    .i_push  (w_push_b),
    .i_din   (b_data),
    .i_pop   (w_pop_b),
    .o_head  (w_head_b),
    .o_empty (w_empty_b),
    .o_drop  (w_drop_b)
  );

  // Pop decision and next state. A state change never emits on the same
  // cycle, which keeps done strictly after the final update.
  always_comb begin
    w_next  = r_state;
    w_pop_a = 1'b0;
    w_pop_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) w_next = S_MERGE;
      end
      S_MERGE: begin
        if (!w_empty_a && !w_empty_b) begin
          // Ties go to A
          if (w_head_a <= w_head_b) w_pop_a = 1'b1;
          else                      w_pop_b = 1'b1;
        end else if (w_empty_a && w_empty_b && r_a_fin && r_b_fin) begin
          w_next = S_DONE;
        end else if (w_empty_a && r_a_fin) begin
          w_next = S_DRAIN_B;
        end else if (w_empty_b && r_b_fin) begin
          w_next = S_DRAIN_A;
        end
      end
      S_DRAIN_A: begin
        if (!w_empty_a)   w_pop_a = 1'b1;
        else if (r_a_fin) w_next  = S_DONE;
      end
      S_DRAIN_B: begin
        if (!w_empty_b)   w_pop_b = 1'b1;
        else if (r_b_fin) w_next  = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_emit      = w_pop_a || w_pop_b;
  assign w_emit_data = w_pop_a ? w_head_a : w_head_b;

  // End-of-stream flags: cleared on load, then that cycle's done is applied
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_fin <= 1'b0;
      r_b_fin <= 1'b0;
    end else if (w_load_acc) begin
      r_a_fin <= a_done;
      r_b_fin <= b_done;
    end else if (w_accept_in) begin
      if (a_done) r_a_fin <= 1'b1;
      if (b_done) r_b_fin <= 1'b1;
    end
  end

  // FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      update      <= 1'b0;
      sorted_data <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      out_count   <= '0;
    end else begin
      r_state <= w_next;
      update  <= w_emit;
      if (w_emit) sorted_data <= w_emit_data;
      done    <= (w_next == S_DONE);
      busy    <= (w_next != S_IDLE);
      if (w_load_acc)               overflow <= 1'b0;
      else if (w_drop_a || w_drop_b) overflow <= 1'b1;
      if (w_load_acc) out_count <= '0;
      else            out_count <= out_count + {{(CNT_W-1){1'b0}}, w_emit};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_merge_layer_2_1_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge_layer_2_1_rx
// Purpose  : Self-checking bench for merge_layer_2_1_rx. Directed scenarios
//            plus randomized sorted streams; expected output is the sorted
//            union of both input streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_merge_layer_2_1_rx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst, load;
  logic          a_update, a_done, b_update, b_done;
  logic [DW-1:0] a_data, b_data;
  logic          update, done, busy, overflow;
  logic [DW-1:0] sorted_data;
  logic [CW-1:0] out_count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] got_q [$];
  int            done_total = 0;
  int            coincide   = 0;
  logic [DW-1:0] ga [$];
  logic [DW-1:0] gb [$];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  merge_layer_2_1_rx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .a_update    (a_update),
    .a_data      (a_data),
    .a_done      (a_done),
    .b_update    (b_update),
    .b_data      (b_data),
    .b_done      (b_done),
    .update      (update),
    .sorted_data (sorted_data),
    .done        (done),
    .busy        (busy),
    .overflow    (overflow),
    .out_count   (out_count)
  );

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (update) got_q.push_back(sorted_data);
    if (done) done_total++;
    if (update && done) coincide++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    load = 0; a_update = 0; a_done = 0; b_update = 0; b_done = 0;
    a_data = '0; b_data = '0;
  endtask

  task automatic do_load();
    load = 1;
    step();
    load = 0;
  endtask

  // Reference: merged ascending stream is the sorted union of both inputs
  task automatic build_expected();
    exp_q.delete();
    foreach (ga[i]) exp_q.push_back(ga[i]);
    foreach (gb[i]) exp_q.push_back(gb[i]);
    exp_q.sort();
  endtask

  // Drive ga/gb with random interleaving; done may coincide with the last push
  task automatic send_streams();
    int  ia = 0;
    int  ib = 0;
    bit  ad = 0;
    bit  bd = 0;
    while (!(ad && bd)) begin
      if (ia < ga.size() && $urandom_range(0, 1) == 1) begin
        a_update = 1; a_data = ga[ia]; ia++;
      end
      if (ia == ga.size() && !ad && $urandom_range(0, 2) == 0) begin
        a_done = 1; ad = 1;
      end
      if (ib < gb.size() && $urandom_range(0, 1) == 1) begin
        b_update = 1; b_data = gb[ib]; ib++;
      end
      if (ib == gb.size() && !bd && $urandom_range(0, 2) == 0) begin
        b_done = 1; bd = 1;
      end
      step();
      clear_in();
    end
  endtask

  task automatic gen_stream(output logic [DW-1:0] q [$]);
    int len = $urandom_range(0, DEPTH);
    int v   = $urandom_range(0, 255);
    q = {};
    for (int i = 0; i < len; i++) begin
      q.push_back(v[DW-1:0]);
      v = v + $urandom_range(0, 3);
      if (v > 255) v = 255;
    end
  endtask

  // Wait for completion, then compare stream, done count and flags
  task automatic finish_check(input string tag, input int base_got, input int base_done,
                              input logic exp_ovf);
    int n = 0;
    while (done_total == base_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_total != base_done), 32'd1);
    step(); step(); step();
    check({tag, "_len"}, 32'(got_q.size() - base_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_got + i < got_q.size())
        check($sformatf("%s_elem%0d", tag, i), 32'(got_q[base_got + i]), 32'(exp_q[i]));
    end
    check({tag, "_done_count"}, 32'(done_total - base_done), 32'd1);
    check({tag, "_out_count"}, 32'(out_count), 32'(exp_q.size()));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_no_coincide"}, 32'(coincide), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_update"}, 32'(update), 32'd0);
    check({tag, "_data"}, 32'(sorted_data), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    int bg, bd, n;
    clear_in();
    rst = 1;
    step(); step();
    rst = 0;
    check_all_zero("reset");

    // 1: interleaved A={1,4,9}, B={2,3,10}
    ga = '{8'd1, 8'd4, 8'd9}; gb = '{8'd2, 8'd3, 8'd10};
    build_expected();
    bg = got_q.size(); bd = done_total;
    do_load(); send_streams();
    finish_check("t1", bg, bd, 1'b0);

    // 2: A empty, B={3,7}
    ga = {}; gb = '{8'd3, 8'd7};
    build_expected();
    bg = got_q.size(); bd = done_total;
    do_load(); send_streams();
    finish_check("t2", bg, bd, 1'b0);

    // 3: stall while B has no data and no done
    exp_q = '{8'd1, 8'd2, 8'd8};
    bg = got_q.size(); bd = done_total;
    do_load();
    a_update = 1; a_data = 8'd2; a_done = 1; b_update = 1; b_data = 8'd1;
    step(); clear_in();
    for (int i = 0; i < 10; i++) step();
    check("t3_gap_len", 32'(got_q.size() - bg), 32'd1);
    check("t3_busy_stall", 32'(busy), 32'd1);
    b_update = 1; b_data = 8'd8; b_done = 1;
    step(); clear_in();
    finish_check("t3", bg, bd, 1'b0);

    // 4: overflow, six pushes into a four-entry FIFO
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    bg = got_q.size(); bd = done_total;
    do_load();
    for (int i = 1; i <= 6; i++) begin
      a_update = 1; a_data = DW'(10 * i);
      step();
    end
    clear_in();
    step();
    check("t4_overflow_set", 32'(overflow), 32'd1);
    b_done = 1; step(); clear_in();
    a_done = 1; step(); clear_in();
    finish_check("t4", bg, bd, 1'b1);

    // 5: boundary values, tie on FF, ignored load mid-merge
    exp_q = '{8'h00, 8'hFF, 8'hFF};
    bg = got_q.size(); bd = done_total;
    do_load();
    check("t5_overflow_cleared", 32'(overflow), 32'd0);
    a_update = 1; a_data = 8'h00; b_update = 1; b_data = 8'hFF;
    step(); clear_in();
    a_update = 1; a_data = 8'hFF;
    step(); clear_in();
    step();
    load = 1; step(); load = 0;
    step();
    check("t5_busy_after_load", 32'(busy), 32'd1);
    a_done = 1; b_done = 1; step(); clear_in();
    finish_check("t5", bg, bd, 1'b0);

    // 6: reset mid-merge after two outputs
    bg = got_q.size(); bd = done_total;
    do_load();
    a_update = 1; a_data = 8'd1; b_update = 1; b_data = 8'd4; step(); clear_in();
    a_update = 1; a_data = 8'd2; b_update = 1; b_data = 8'd5; step(); clear_in();
    a_update = 1; a_data = 8'd3; step(); clear_in();
    n = 0;
    while (got_q.size() - bg < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_out", 32'(got_q.size() - bg >= 2), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_all_zero("t6_rst");
    bg = got_q.size();
    for (int i = 0; i < 5; i++) step();
    check("t6_quiet_upd", 32'(got_q.size() - bg), 32'd0);
    check("t6_quiet_done", 32'(done_total - bd), 32'd0);
    ga = '{8'd5, 8'd6}; gb = '{8'd6};
    build_expected();
    bg = got_q.size(); bd = done_total;
    do_load(); send_streams();
    finish_check("t6_fresh", bg, bd, 1'b0);

    // Randomized sorted streams
    for (int t = 0; t < 20; t++) begin
      gen_stream(ga);
      gen_stream(gb);
      build_expected();
      bg = got_q.size(); bd = done_total;
      do_load(); send_streams();
      finish_check($sformatf("rnd%0d", t), bg, bd, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
